// File: rtl/flit_sink_if.sv
// flit_sink_if: link between a router output port and the ejection endpoint.
//
// Handshake: flow control is credit-based, with no ready signal. The router
// asserts `read` for one cycle per flit, and `in_port` holds that flit in the
// same cycle. For every flit it consumes, the sink returns a one-cycle pulse on
// `out_credit[vc]`. The router must never have more flits outstanding on a VC
// than that VC's buffer depth.
//
// Signals:
//   in_port    - flit {dest, source, head, tail, vc}   (router -> sink)
//   read       - flit-valid strobe                      (router -> sink)
//   out_credit - per-VC credit pulse                    (sink -> router)
interface flit_sink_if #(
   parameter int flit_size  = 30,
   parameter int num_of_vcs = 2
) ();
   logic [flit_size-1:0]  in_port;
   logic                  read;
   logic [num_of_vcs-1:0] out_credit;

   modport master (output in_port, output read, input out_credit);
   modport slave  (input in_port, input read, output out_credit);
endinterface

// File: rtl/flit_sink.sv
// flit_sink: ejection endpoint for a router's local port.
//
// The sink buffers incoming flits in one FIFO per VC. Each cycle it drains one
// flit, picking the VC by round-robin. It returns a delayed credit for each
// drained flit, checks packet framing and destination, and counts packets and
// flits. `done` means every expected packet has arrived and the sink is idle.
//
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   rx                - flit_sink_if slave (in_port, read, out_credit)
//   expected_packets  - number of packets to receive before done
//   pkt_count         - completed packets (saturating)
//   flit_count        - consumed flits (saturating)
//   err               - sticky flags {orphan, head-in-packet, bad dest, overflow}
//   done              - reception complete (registered)
//   fsm_state_o       - framing state per VC (1 = inside a packet)
module flit_sink #(
   parameter int flit_size                      = 30,
   parameter int node_id_size                   = 10,
   parameter int ID                             = 0,
   parameter int num_of_vcs                     = 2,
   parameter int vcs_size                       = 2,
   parameter int buffer_addr_w                  = 1,
   parameter int num_credit_delay               = 1,
   parameter int entries_addr_w                 = 10,
   parameter int max_num_of_packet_flits_addr_w = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   flit_sink_if.slave               rx,
   input  logic [entries_addr_w-1:0] expected_packets,
   output logic [entries_addr_w-1:0] pkt_count,
   output logic [entries_addr_w+max_num_of_packet_flits_addr_w-1:0] flit_count,
   output logic [3:0]                err,
   output logic                      done,
   output logic [num_of_vcs-1:0]     fsm_state_o
);

   localparam int DEPTH    = 1 << buffer_addr_w;
   localparam int FCW      = entries_addr_w + max_num_of_packet_flits_addr_w;
   localparam int RW       = (num_of_vcs > 1) ? $clog2(num_of_vcs) : 1;
   localparam int HEAD_BIT = flit_size - 2*node_id_size - 1;
   localparam int TAIL_BIT = HEAD_BIT - 1;
   localparam logic [buffer_addr_w:0]  FULL_CNT = (buffer_addr_w+1)'(DEPTH);
   localparam logic [node_id_size-1:0] MY_ID    = node_id_size'(ID);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_IN_PKT = 1'b1;

   // Per-VC FIFO storage and pointers
   logic [flit_size-1:0]     mem_q    [num_of_vcs][DEPTH];
   logic [buffer_addr_w-1:0] wr_ptr_q [num_of_vcs];
   logic [buffer_addr_w-1:0] rd_ptr_q [num_of_vcs];
   logic [buffer_addr_w:0]   cnt_q    [num_of_vcs];
   logic [0:0]               state_q  [num_of_vcs];

   logic [RW-1:0]               rr_q;
   logic [num_of_vcs-1:0]       cred_q [num_credit_delay];
   logic [entries_addr_w-1:0]   pkt_count_q;
   logic [FCW-1:0]              flit_count_q;
   logic [3:0]                  err_q, err_d;
   logic                        done_q, done_d;

   // Write side
   logic [vcs_size-1:0]   wr_vc_raw;
   logic                  wr_vc_ok;
   logic [RW-1:0]         wr_vc;
   logic                  push, overflow;
   logic [num_of_vcs-1:0] push_vec, pop_vec;

   // Drain side
   logic                  gnt_valid;
   logic [RW-1:0]         gnt_vc;
   logic [flit_size-1:0]  pop_flit;
   logic                  pop_head, pop_tail;
   logic [0:0]            cur_state, nxt_state;
   logic                  pkt_done, e_head, e_orphan, e_dest;
   logic                  all_empty, cred_any;
   logic                  unused_flit_bits;

   assign wr_vc_raw = rx.in_port[vcs_size-1:0];
   assign wr_vc_ok  = int'(wr_vc_raw) < num_of_vcs;
   assign wr_vc     = RW'(wr_vc_raw);

   // Round-robin grant: first non-empty VC starting at the pointer
   always_comb begin
      int idx;
      idx       = 0;
      gnt_valid = 1'b0;
      gnt_vc    = '0;
      for (int i = 0; i < num_of_vcs; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= num_of_vcs) idx = idx - num_of_vcs;
         if (!gnt_valid && cnt_q[idx] != '0) begin
            gnt_valid = 1'b1;
            gnt_vc    = RW'(idx);
         end
      end
   end

   // A full VC may still accept a flit when it is draining in the same cycle
   always_comb begin
      push = 1'b0;
      if (rx.read && wr_vc_ok)
         push = (cnt_q[wr_vc] != FULL_CNT) || (gnt_valid && gnt_vc == wr_vc);
      overflow = rx.read && !push;
   end

   always_comb begin
      push_vec = '0;
      pop_vec  = '0;
      for (int v = 0; v < num_of_vcs; v++) begin
         push_vec[v] = push && (wr_vc == RW'(v));
         pop_vec[v]  = gnt_valid && (gnt_vc == RW'(v));
      end
   end

   assign pop_flit = mem_q[gnt_vc][rd_ptr_q[gnt_vc]];
   assign pop_head = pop_flit[HEAD_BIT];
   assign pop_tail = pop_flit[TAIL_BIT];
   assign unused_flit_bits = ^{pop_flit[flit_size-node_id_size-1:HEAD_BIT+1],
                               pop_flit[TAIL_BIT-1:0]};

   // Framing check on the popped flit
   always_comb begin
      cur_state = state_q[gnt_vc];
      nxt_state = cur_state;
      pkt_done  = 1'b0;
      e_head    = 1'b0;
      e_orphan  = 1'b0;
      e_dest    = 1'b0;
      if (gnt_valid) begin
         e_dest = pop_flit[flit_size-1:flit_size-node_id_size] != MY_ID;
         if (pop_head) begin
            // A head inside a packet abandons the old packet and restarts
            e_head    = (cur_state == S_IN_PKT);
            pkt_done  = pop_tail;
            nxt_state = pop_tail ? S_IDLE : S_IN_PKT;
         end else if (cur_state == S_IDLE) begin
            e_orphan = 1'b1;
         end else if (pop_tail) begin
            pkt_done  = 1'b1;
            nxt_state = S_IDLE;
         end
      end
   end

   always_comb begin
      all_empty = 1'b1;
      for (int v = 0; v < num_of_vcs; v++)
         if (cnt_q[v] != '0) all_empty = 1'b0;
      cred_any = 1'b0;
      for (int k = 0; k < num_credit_delay; k++)
         if (cred_q[k] != '0) cred_any = 1'b1;
      err_d  = err_q | {e_orphan, e_head, e_dest, overflow};
      done_d = (pkt_count_q >= expected_packets) && all_empty && !cred_any && !rx.read;
   end

   // FIFO storage is not reset; validity is tracked by cnt_q
   always_ff @(posedge clk) begin
      for (int v = 0; v < num_of_vcs; v++)
         if (push_vec[v]) mem_q[v][wr_ptr_q[v]] <= rx.in_port;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int v = 0; v < num_of_vcs; v++) begin
            wr_ptr_q[v] <= '0;
            rd_ptr_q[v] <= '0;
            cnt_q[v]    <= '0;
            state_q[v]  <= S_IDLE;
         end
         for (int k = 0; k < num_credit_delay; k++) cred_q[k] <= '0;
         rr_q         <= '0;
         pkt_count_q  <= '0;
         flit_count_q <= '0;
         err_q        <= '0;
         done_q       <= 1'b0;
      end else begin
         for (int v = 0; v < num_of_vcs; v++) begin
            if (push_vec[v]) wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
            if (pop_vec[v])  rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
            case ({push_vec[v], pop_vec[v]})
               2'b10:   cnt_q[v] <= cnt_q[v] + 1'b1;
               2'b01:   cnt_q[v] <= cnt_q[v] - 1'b1;
               default: cnt_q[v] <= cnt_q[v];
            endcase
         end
         if (gnt_valid) begin
            state_q[gnt_vc] <= nxt_state;
            rr_q <= (int'(gnt_vc) == num_of_vcs-1) ? '0 : gnt_vc + 1'b1;
            if (flit_count_q != '1) flit_count_q <= flit_count_q + 1'b1;
         end
         if (pkt_done && pkt_count_q != '1) pkt_count_q <= pkt_count_q + 1'b1;
         cred_q[0] <= pop_vec;
         for (int k = 1; k < num_credit_delay; k++) cred_q[k] <= cred_q[k-1];
         err_q  <= err_d;
         done_q <= done_d;
      end
   end

   assign rx.out_credit = cred_q[num_credit_delay-1];
   assign pkt_count     = pkt_count_q;
   assign flit_count    = flit_count_q;
   assign err           = err_q;
   assign done          = done_q;

   always_comb begin
      fsm_state_o = '0;
      for (int v = 0; v < num_of_vcs; v++) fsm_state_o[v] = state_q[v][0];
   end

endmodule

// File: tb/tb_flit_sink.sv
// tb_flit_sink: directed self-checking bench for flit_sink.
//
// For each flit that should be consumed, the bench queues the expected credit
// lane. A negedge monitor pops that queue for every credit pulse it sees.
// Counters, error flags, done and reset behaviour are checked at fixed
// points, 1 time unit after a clock edge.
module tb_flit_sink;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  expected_packets;
   logic [9:0]  pkt_count;
   logic [17:0] flit_count;
   logic [3:0]  err;
   logic        done;
   logic [1:0]  fsm_state;

   int checks = 0;
   int errors = 0;
   logic [1:0] exp_q[$];

   flit_sink_if #(.flit_size(30), .num_of_vcs(2)) bus ();

   flit_sink dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rx               (bus),
      .expected_packets (expected_packets),
      .pkt_count        (pkt_count),
      .flit_count       (flit_count),
      .err              (err),
      .done             (done),
      .fsm_state_o      (fsm_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [29:0] mk(input int dest, input logic head,
                                      input logic tail, input logic [7:0] vc);
      return {10'(dest), 10'd5, head, tail, vc};
   endfunction

   // Driver: one flit in the cycle ending at the next posedge
   task automatic send(input logic [29:0] f, input bit want_credit);
      bus.in_port = f;
      bus.read    = 1'b1;
      @(posedge clk);
      #1;
      bus.read = 1'b0;
      if (want_credit) exp_q.push_back(2'b01 << f[0]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
   endtask

   // Scoreboard: every credit pulse must match the oldest expected lane
   always @(negedge clk) begin
      if (bus.out_credit !== 2'b00) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL credit_unexpected: observed %b expected none", bus.out_credit);
         end else begin
            chk("credit_lane", 32'(bus.out_credit), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      bus.in_port      = '0;
      bus.read         = 1'b0;
      expected_packets = '0;
      rst_n            = 1'b0;

      // Reset state
      idle(2);
      chk("rst_pkt", 32'(pkt_count), 0);
      chk("rst_flit", 32'(flit_count), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_credit", 32'(bus.out_credit), 0);
      rst_n = 1'b1;
      idle(1);
      chk("done_zero_expected", 32'(done), 1);

      // Single-flit packet and credit latency
      expected_packets = 10'd1;
      send(mk(0, 1, 1, 8'd0), 1);
      idle(1);
      chk("credit_pulse_on", 32'(bus.out_credit), 32'h1);
      idle(1);
      chk("credit_pulse_off", 32'(bus.out_credit), 0);
      idle(2);
      chk("single_pkt", 32'(pkt_count), 1);
      chk("single_flit", 32'(flit_count), 1);
      chk("single_done", 32'(done), 1);
      chk("single_err", 32'(err), 0);

      // Two interleaved 3-flit packets
      expected_packets = 10'd3;
      send(mk(0, 1, 0, 8'd0), 1);
      send(mk(0, 1, 0, 8'd1), 1);
      send(mk(0, 0, 0, 8'd0), 1);
      send(mk(0, 0, 0, 8'd1), 1);
      send(mk(0, 0, 1, 8'd0), 1);
      send(mk(0, 0, 1, 8'd1), 1);
      idle(5);
      chk("ilv_pkt", 32'(pkt_count), 3);
      chk("ilv_flit", 32'(flit_count), 7);
      chk("ilv_err", 32'(err), 0);
      chk("ilv_done", 32'(done), 1);

      // Back-to-back on VC0: no overflow
      send(mk(0, 1, 0, 8'd0), 1);
      send(mk(0, 0, 0, 8'd0), 1);
      send(mk(0, 0, 0, 8'd0), 1);
      send(mk(0, 0, 1, 8'd0), 1);
      idle(4);
      chk("b2b_pkt", 32'(pkt_count), 4);
      chk("b2b_err", 32'(err), 0);

      // Head inside a packet: old packet abandoned
      send(mk(0, 1, 0, 8'd0), 1);
      send(mk(0, 1, 0, 8'd0), 1);
      send(mk(0, 0, 1, 8'd0), 1);
      idle(4);
      chk("dhead_pkt", 32'(pkt_count), 5);
      chk("dhead_flit", 32'(flit_count), 14);
      chk("dhead_err", 32'(err), 32'h4);

      // Wrong destination, still counted
      send(mk(1, 1, 1, 8'd1), 1);
      idle(4);
      chk("dest_err", 32'(err), 32'h6);
      chk("dest_pkt", 32'(pkt_count), 6);

      // Orphan tail on idle VC0
      send(mk(0, 0, 1, 8'd0), 1);
      idle(4);
      chk("orphan_err", 32'(err), 32'hE);
      chk("orphan_pkt", 32'(pkt_count), 6);
      chk("orphan_flit", 32'(flit_count), 16);

      // Out-of-range VC is dropped as overflow
      send(mk(0, 1, 1, 8'd2), 0);
      idle(4);
      chk("badvc_err", 32'(err), 32'hF);
      chk("badvc_flit", 32'(flit_count), 16);

      // done with expected_packets = 2
      expected_packets = 10'd2;
      do_reset();
      idle(1);
      chk("exp2_err_cleared", 32'(err), 0);
      send(mk(0, 1, 1, 8'd1), 1);
      idle(4);
      chk("exp2_one_pkt", 32'(pkt_count), 1);
      chk("exp2_not_done", 32'(done), 0);
      send(mk(0, 1, 1, 8'd0), 1);
      idle(4);
      chk("exp2_done", 32'(done), 1);
      send(mk(0, 1, 1, 8'd1), 1);
      chk("stray_done_drop", 32'(done), 0);
      idle(4);
      chk("stray_done_back", 32'(done), 1);
      chk("stray_pkt", 32'(pkt_count), 3);

      // Reset mid-packet with a flit still buffered
      send(mk(0, 1, 0, 8'd0), 1);
      bus.in_port = mk(0, 0, 0, 8'd0);
      bus.read    = 1'b1;
      @(posedge clk);
      #1;
      bus.read = 1'b0;
      chk("mid_fsm_inpkt", 32'(fsm_state), 32'h1);
      rst_n = 1'b0;
      idle(1);
      chk("mid_rst_credit", 32'(bus.out_credit), 0);
      chk("mid_rst_pkt", 32'(pkt_count), 0);
      chk("mid_rst_flit", 32'(flit_count), 0);
      chk("mid_rst_err", 32'(err), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_fsm", 32'(fsm_state), 0);
      rst_n = 1'b1;
      idle(5);
      chk("post_rst_flit", 32'(flit_count), 0);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/flit_sink.md
# flit_sink

Ejection endpoint for a router's local port (port 0). It is the receive-side counterpart of the CPU traffic injector. It accepts flits written by the router and buffers them per virtual channel. It then consumes them one per cycle, returns one credit per consumed flit, checks packet framing and destination, and counts completed packets. It raises `done` once the configured number of packets has arrived and all buffers and credits have drained, which feeds the top-level `all_done` reduction.

## Interface
- `flit_size`, 30, flit width; layout {dest[29:20], source[19:10], head[9], tail[8], vc[7:0]}
- `node_id_size`, 10, width of the dest/source fields
- `ID`, 0, node id of this endpoint; flits must carry dest == ID
- `num_of_vcs`, 2, number of virtual channels
- `vcs_size`, 2, low bits of the vc field used as VC index
- `buffer_addr_w`, 1, per-VC buffer depth = 2^buffer_addr_w
- `num_credit_delay`, 1, cycles from flit consumption to credit pulse (>=1)
- `entries_addr_w`, 10, width of packet counter and expected-count input
- `max_num_of_packet_flits_addr_w`, 8, added to entries_addr_w for flit counter width

Ports:
- `clk`, in, 1, clock; all logic on posedge
- `rst_n`, in, 1, reset; synchronous, active-low
- `in_port`, in, flit_size, flit from router output port 0
- `read`, in, 1, flit-valid strobe (router `write`); one flit per asserted cycle
- `expected_packets`, in, entries_addr_w, packets to receive before done; sampled continuously
- `out_credit`, out, num_of_vcs, one-cycle credit pulse per VC back to router
- `pkt_count`, out, entries_addr_w, completed packets
- `flit_count`, out, entries_addr_w+max_num_of_packet_flits_addr_w, consumed flits
- `err`, out, 4, sticky error flags
- `done`, out, 1, reception complete

## Operation
- Write: when `read`=1, VC v = in_port[vcs_size-1:0]. If buffer v is not full, or buffer v is full and is granted for drain in that same cycle, the flit is appended to FIFO v. Otherwise the flit is dropped and err[0] (overflow) is set.
- A VC index >= num_of_vcs is treated as overflow: the flit is dropped and err[0] is set.
- Drain: each cycle at most one non-empty VC is granted, by round-robin. The pointer resets to VC0. After granting v, the pointer becomes (v+1) mod num_of_vcs. The granted head flit is popped.
- Credit: a pop from VC v injects a 1 into a num_credit_delay-deep shift pipe at lane v. `out_credit` is the pipe output.
- Framing FSM per VC, states IDLE and IN_PKT, evaluated on popped flits:
  - IDLE + head: if tail=1, the packet is complete and the state stays IDLE; otherwise go to IN_PKT.
  - IDLE + non-head: set err[3] (orphan body/tail); state stays IDLE.
  - IN_PKT + head: set err[2]; treat the flit as a new packet head. The abandoned packet is not counted.
  - IN_PKT + tail: the packet is complete; go to IDLE.
- Every popped flit with dest != ID sets err[1]. The flit is still processed by the FSM.
- Packet complete: pkt_count += 1, saturating at all-ones.
- Every pop: flit_count += 1, saturating at all-ones.
- `done` is registered. It is 1 when pkt_count >= expected_packets, all FIFOs are empty, the credit pipe is all-zero, and `read`=0; otherwise it is 0. It deasserts if a later flit arrives.
- `err` bits are sticky until reset.

## Timing
- Reset values: out_credit=0, pkt_count=0, flit_count=0, err=0, done=0, all FIFOs empty, FSMs IDLE, RR pointer=0.
- A flit written at edge N is poppable at edge N+1 at the earliest, which gives 1-cycle minimum buffering.
- A pop at edge P produces `out_credit[v]`=1 for exactly the cycle after edge P+num_credit_delay-1, i.e. visible num_credit_delay cycles after the pop.
- pkt_count and flit_count update at the pop edge. `done` updates one edge after its condition holds.
- Throughput: 1 flit/cycle total sustained. The router must hold at most 2^buffer_addr_w outstanding per VC.
- A reset asserted mid-packet clears everything at the next edge. Credits in flight are discarded.
- With expected_packets=0 and no traffic, done=1 one edge after reset is released.

## Test plan
- Single-flit packet (head=1, tail=1, dest=ID, vc=0), expected_packets=1 -> popped next cycle, out_credit=2'b01 for one cycle after num_credit_delay, pkt_count=1, flit_count=1, done=1, err=0.
- Two interleaved 3-flit packets on VC0/VC1 written back-to-back -> pops alternate VC0,VC1, pkt_count=2, flit_count=6, six credit pulses (three per lane), err=0.
- Write to VC0 every cycle for 4 cycles, depth 2 -> no overflow, because the drain keeps pace; then two consecutive head flits on VC0 -> err[2]=1, pkt_count unaffected by the abandoned packet.
- Flit with dest=ID+1 -> err[1]=1. A body flit sent first on an idle VC -> err[3]=1, pkt_count stays 0.
- expected_packets=2 with one packet received -> done=0; second packet arrives -> done=1; a stray flit afterwards -> done drops to 0 while it is buffered.
- rst_n=0 mid-packet with credits pending -> all outputs return to reset values at the next edge, and no credit pulse appears afterwards.
